// File: rtl/pl_dmem_pkg.sv
// Shared control encodings for the pipelined computer: data-memory access
// types and the pl_dmem FSM states.
package pl_dmem_pkg;

  // Data-memory access type (dmtype)
  localparam logic [2:0] DM_WORD              = 3'b000;
  localparam logic [2:0] DM_HALFWORD          = 3'b001;
  localparam logic [2:0] DM_HALFWORD_UNSIGNED = 3'b010;
  localparam logic [2:0] DM_BYTE              = 3'b011;
  localparam logic [2:0] DM_BYTE_UNSIGNED     = 3'b100;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } dm_state_e;

  // Encodings 5..7 are unused and must be rejected.
  function automatic logic dm_type_valid(logic [2:0] t);
    return t <= DM_BYTE_UNSIGNED;
  endfunction

  // High when the low address bits do not match the natural alignment of t.
  function automatic logic dm_misaligned(logic [2:0] t, logic [1:0] off);
    logic mis;
    mis = 1'b0;
    if (t == DM_WORD) begin
      mis = (off != 2'b00);
    end else if (t == DM_HALFWORD || t == DM_HALFWORD_UNSIGNED) begin
      mis = off[0];
    end
    return mis;
  endfunction

endpackage

// File: rtl/dm_lane.sv
// Combinational byte-lane steering for pl_dmem: write byte enables and
// positioned store data, plus load extraction with sign/zero extension.
// Halfword lanes use only offset[1], so a stray offset[0] is ignored.
module dm_lane
  import pl_dmem_pkg::*;
(
  input  logic [2:0]  dmtype,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wword,
  output logic [31:0] rext
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed lanes of the raw word
  always_comb begin
    byte_sel = rword[{offset, 3'b000} +: 8];
    half_sel = offset[1] ? rword[31:16] : rword[15:0];
  end

  // Steer enables/data per access type; unknown types touch nothing
  always_comb begin
    be    = 4'b0000;
    wword = 32'h0;
    rext  = 32'h0;
    case (dmtype)
      DM_WORD: begin
        be    = 4'b1111;
        wword = wdata;
        rext  = rword;
      end
      DM_HALFWORD: begin
        be    = offset[1] ? 4'b1100 : 4'b0011;
        wword = {2{wdata[15:0]}};
        rext  = {{16{half_sel[15]}}, half_sel};
      end
      DM_HALFWORD_UNSIGNED: begin
        be    = offset[1] ? 4'b1100 : 4'b0011;
        wword = {2{wdata[15:0]}};
        rext  = {16'h0, half_sel};
      end
      DM_BYTE: begin
        be    = 4'b0001 << offset;
        wword = {4{wdata[7:0]}};
        rext  = {{24{byte_sel[7]}}, byte_sel};
      end
      DM_BYTE_UNSIGNED: begin
        be    = 4'b0001 << offset;
        wword = {4{wdata[7:0]}};
        rext  = {24'h0, byte_sel};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/pl_dmem.sv
// Handshaked data memory with configurable wait states.
// One request at a time: IDLE -> (WAIT x WAIT_CYCLES) -> RESP -> IDLE.
// The array is touched only on the edge entering RESP; with no wait states
// that is the accept edge itself, so the live inputs are used there.
// Optional macro DMEM_MISALIGN_CHECK_EN: misaligned halfword/word accesses
// complete with err=1; otherwise low address bits are ignored.
// DEPTH_WORDS must be a power of two, at least 2.
module pl_dmem
  import pl_dmem_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        dmtype,
  input  logic [31:0]       wdata,
  output logic              ready,
  output logic              done,
  output logic [31:0]       rdata,
  output logic              err
);

  localparam int unsigned IdxW = $clog2(DEPTH_WORDS);

  dm_state_e         state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        dmtype_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic              err_q;

  logic [31:0]       mem [DEPTH_WORDS];

  logic              accept, access;
  logic              a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [2:0]        a_type;
  logic [31:0]       a_wdata;
  logic              out_of_range, misaligned, acc_err;
  logic [IdxW-1:0]   idx;
  logic [31:0]       rword;
  logic [3:0]        be;
  logic [31:0]       wword, rext;

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and wait-counter logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          if (WAIT_CYCLES > 0) begin
            state_d = StWait;
            cnt_d   = 4'(WAIT_CYCLES - 1);
          end else begin
            state_d = StResp;
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Handshake outputs
  always_comb begin
    ready = (state_q == StIdle);
    done  = (state_q == StResp);
    err   = (state_q == StResp) & err_q;
    rdata = rdata_q;
  end

  // Select operands for the access edge: live inputs when entering RESP from IDLE
  always_comb begin
    accept  = (state_q == StIdle) & req;
    access  = (state_d == StResp) & (state_q != StResp);
    a_we    = (state_q == StIdle) ? we     : we_q;
    a_addr  = (state_q == StIdle) ? addr   : addr_q;
    a_type  = (state_q == StIdle) ? dmtype : dmtype_q;
    a_wdata = (state_q == StIdle) ? wdata  : wdata_q;
  end

  if (IdxW + 2 < ADDR_W) begin : g_range
    assign out_of_range = |a_addr[ADDR_W-1:IdxW+2];
  end else begin : g_full
    assign out_of_range = 1'b0;
  end

`ifdef DMEM_MISALIGN_CHECK_EN
  assign misaligned = dm_misaligned(a_type, a_addr[1:0]);
`else
  assign misaligned = 1'b0;
`endif

  // Classify the access and read the addressed word
  always_comb begin
    acc_err = out_of_range | ~dm_type_valid(a_type) | misaligned;
    idx     = a_addr[IdxW+1:2];
    rword   = mem[idx];
  end

  dm_lane u_lane (
    .dmtype (a_type),
    .offset (a_addr[1:0]),
    .wdata  (a_wdata),
    .rword  (rword),
    .be     (be),
    .wword  (wword),
    .rext   (rext)
  );

  // Capture the request on acceptance so the inputs may change during WAIT
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      we_q     <= 1'b0;
      addr_q   <= '0;
      dmtype_q <= 3'b000;
      wdata_q  <= 32'h0;
    end else if (accept) begin
      we_q     <= we;
      addr_q   <= addr;
      dmtype_q <= dmtype;
      wdata_q  <= wdata;
    end
  end

  // Register the load result and error on the access edge; stores keep rdata
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else if (access) begin
      err_q <= acc_err;
      if (acc_err) begin
        rdata_q <= 32'h0;
      end else if (!a_we) begin
        rdata_q <= rext;
      end
    end
  end

  // Byte-lane writes; contents are not reset. rstn gate blocks a write while held in reset.
  always_ff @(posedge clk) begin
    if (rstn && access && a_we && !acc_err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[idx][8*i +: 8] <= wword[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_pl_dmem.sv
// Scoreboard bench for pl_dmem: two instances (0 and 3 wait states) driven
// sequentially; expected responses come from a byte-array reference model.
module tb_pl_dmem;

  localparam int unsigned Depth = 64;
  localparam int unsigned MBytes = 64;  // model tracks the low 16 words only

  typedef struct {
    int          cyc;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  logic        clk;
  logic        rstn_s  [2];
  logic        req_s   [2];
  logic        we_s    [2];
  logic [31:0] addr_s  [2];
  logic [2:0]  dmt_s   [2];
  logic [31:0] wdata_s [2];
  logic        ready_s [2];
  logic        done_s  [2];
  logic [31:0] rdata_s [2];
  logic        err_s   [2];

  int          cyc;
  int          n_cmp;
  int          n_bad;
  exp_t        q0[$];
  exp_t        q1[$];
  exp_t        me;
  logic [7:0]  mm [2][MBytes];
  logic [31:0] mlast [2];
  logic [31:0] mon_last [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    pl_dmem #(
      .ADDR_W      (32),
      .DEPTH_WORDS (Depth),
      .WAIT_CYCLES ((g == 0) ? 0 : 3)
    ) dut (
      .clk    (clk),
      .rstn   (rstn_s[g]),
      .req    (req_s[g]),
      .we     (we_s[g]),
      .addr   (addr_s[g]),
      .dmtype (dmt_s[g]),
      .wdata  (wdata_s[g]),
      .ready  (ready_s[g]),
      .done   (done_s[g]),
      .rdata  (rdata_s[g]),
      .err    (err_s[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int wait_of(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  task automatic chk(input string nm, input int d, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d: got %h expected %h", nm, d, act, exp);
    end
  endtask

  // Reference model: byte-addressed memory, access rules applied directly.
  task automatic model(input int d, input bit w, input logic [31:0] a, input logic [2:0] t,
                       input logic [31:0] wd, output logic e, output logic [31:0] rd);
    int unsigned size;
    int unsigned ea;
    logic [31:0] v;
    bit sgn;
    size = (t == 3'd0) ? 4 : (t <= 3'd2) ? 2 : 1;
    sgn  = (t == 3'd1) || (t == 3'd3);
    e    = ((a / 4) >= Depth) || (t > 3'd4);
`ifdef DMEM_MISALIGN_CHECK_EN
    if ((a % size) != 0) e = 1'b1;
`endif
    ea = a - (a % size);
    if (e) begin
      rd = 32'h0;
    end else if (w) begin
      for (int i = 0; i < int'(size); i++) mm[d][ea + i] = wd[8*i +: 8];
      rd = mlast[d];
    end else begin
      v = 32'h0;
      for (int i = 0; i < int'(size); i++) v = v | (32'(mm[d][ea + i]) << (8 * i));
      if (sgn && size == 2 && v[15]) v = v | 32'hFFFF0000;
      if (sgn && size == 1 && v[7]) v = v | 32'hFFFFFF00;
      rd = v;
    end
    mlast[d] = rd;
  endtask

  // Raise a request, hold it until accepted, push the expected response.
  task automatic issue(input int d, input bit w, input logic [31:0] a, input logic [2:0] t,
                       input logic [31:0] wd, input bit track);
    int   c;
    bit   got;
    exp_t e;
    got = 0;
    c = 0;
    req_s[d] = 1'b1;
    we_s[d] = w;
    addr_s[d] = a;
    dmt_s[d] = t;
    wdata_s[d] = wd;
    for (int n = 0; n < 50 && !got; n++) begin
      @(negedge clk);
      if (ready_s[d]) begin
        got = 1;
        c = cyc;
      end
    end
    if (!got) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout dut%0d: ready still 0 after 50 cycles, expected 1", d);
      req_s[d] = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    req_s[d] = 1'b0;
    if (track) begin
      model(d, w, a, t, wd, e.err, e.rdata);
      e.cyc = c + 1 + wait_of(d);
      if (d == 0) q0.push_back(e);
      else q1.push_back(e);
    end
  endtask

  // Monitor: compare each done against the scoreboard; outside done check err/rdata hold
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rstn_s[d]) begin
        if (done_s[d]) begin
          if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
            n_cmp++;
            n_bad++;
            $display("FAIL spurious_done dut%0d: done=1 at cycle %0d, expected no response", d,
                     cyc);
          end else begin
            me = (d == 0) ? q0.pop_front() : q1.pop_front();
            chk("done_cycle", d, 32'(cyc), 32'(me.cyc));
            chk("err", d, 32'(err_s[d]), 32'(me.err));
            chk("rdata", d, rdata_s[d], me.rdata);
            mon_last[d] = me.rdata;
          end
        end else begin
          chk("err_idle", d, 32'(err_s[d]), 32'h0);
          chk("rdata_hold", d, rdata_s[d], mon_last[d]);
        end
      end
    end
  end

  initial begin
    int d;
    logic [2:0] t;
    logic [31:0] a;
    int r;
    n_cmp = 0;
    n_bad = 0;
    for (int i = 0; i < 2; i++) begin
      rstn_s[i] = 1'b0;
      req_s[i] = 1'b0;
      we_s[i] = 1'b0;
      addr_s[i] = 32'h0;
      dmt_s[i] = 3'd0;
      wdata_s[i] = 32'h0;
      mlast[i] = 32'h0;
      mon_last[i] = 32'h0;
    end
    repeat (3) @(negedge clk);
    rstn_s[0] = 1'b1;
    rstn_s[1] = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_ready", i, 32'(ready_s[i]), 32'h1);
      chk("rst_done", i, 32'(done_s[i]), 32'h0);
      chk("rst_err", i, 32'(err_s[i]), 32'h0);
      chk("rst_rdata", i, rdata_s[i], 32'h0);
    end
    @(posedge clk);
    #1;

    // Define the modelled region of both memories
    for (int i = 0; i < 2; i++)
      for (int w = 0; w < 16; w++) issue(i, 1'b1, 32'(w * 4), 3'd0, $urandom, 1'b1);

    // Directed, no wait states
    issue(0, 1'b1, 32'h10, 3'd0, 32'h12345678, 1'b1);
    issue(0, 1'b0, 32'h10, 3'd0, 32'h0, 1'b1);
    issue(0, 1'b1, 32'h13, 3'd3, 32'h000000AB, 1'b1);
    issue(0, 1'b0, 32'h10, 3'd0, 32'h0, 1'b1);
    issue(0, 1'b0, 32'h13, 3'd3, 32'h0, 1'b1);
    issue(0, 1'b0, 32'h13, 3'd4, 32'h0, 1'b1);
    issue(0, 1'b0, 32'h12, 3'd1, 32'h0, 1'b1);
    issue(0, 1'b0, 32'(Depth * 4), 3'd0, 32'h0, 1'b1);
    issue(0, 1'b1, 32'(Depth * 4), 3'd0, 32'h55555555, 1'b1);
    issue(0, 1'b0, 32'h10, 3'd7, 32'h0, 1'b1);
    issue(0, 1'b0, 32'h10, 3'd0, 32'h0, 1'b1);
    issue(0, 1'b1, 32'h11, 3'd0, 32'hCAFEF00D, 1'b1);
    issue(0, 1'b0, 32'h10, 3'd0, 32'h0, 1'b1);

    // Wait states: requests during the busy window are ignored
    issue(1, 1'b0, 32'h08, 3'd0, 32'h0, 1'b1);
    req_s[1] = 1'b1;
    we_s[1] = 1'b1;
    addr_s[1] = 32'h24;
    dmt_s[1] = 3'd0;
    wdata_s[1] = 32'h0BADF00D;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("busy_ready", 1, 32'(ready_s[1]), 32'h0);
    end
    @(posedge clk);
    #1;
    req_s[1] = 1'b0;
    @(negedge clk);
    chk("ready_back", 1, 32'(ready_s[1]), 32'h1);
    @(posedge clk);
    #1;
    issue(1, 1'b0, 32'h24, 3'd0, 32'h0, 1'b1);

    // Reset during WAIT abandons the store
    issue(1, 1'b1, 32'h20, 3'd0, 32'hDEADBEEF, 1'b0);
    @(posedge clk);
    #1;
    rstn_s[1] = 1'b0;
    mlast[1] = 32'h0;
    mon_last[1] = 32'h0;
    @(negedge clk);
    chk("midrst_ready", 1, 32'(ready_s[1]), 32'h1);
    chk("midrst_done", 1, 32'(done_s[1]), 32'h0);
    chk("midrst_rdata", 1, rdata_s[1], 32'h0);
    @(negedge clk);
    rstn_s[1] = 1'b1;
    @(posedge clk);
    #1;
    issue(1, 1'b0, 32'h20, 3'd0, 32'h0, 1'b1);

    // Random traffic
    for (int k = 0; k < 120; k++) begin
      d = k % 2;
      r = $urandom_range(0, 9);
      t = (r <= 8) ? 3'(r % 5) : 3'($urandom_range(5, 7));
      a = ($urandom_range(0, 7) == 0) ? 32'(Depth * 4 + $urandom_range(0, 255))
                                      : 32'($urandom_range(0, 63));
      issue(d, 1'($urandom), a, t, $urandom, 1'b1);
    end

    // Drain
    for (int i = 0; i < 40 && (q0.size() != 0 || q1.size() != 0); i++) @(negedge clk);
    if (q0.size() != 0 || q1.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d/%0d responses outstanding, expected 0/0", q0.size(), q1.size());
    end
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pl_dmem.md
# pl_dmem

Parametrised, handshaked data memory that replaces the single-cycle data RAM in the pipelined computer. It accepts one load/store request at a time. Each request completes after a configurable number of wait states. Byte, halfword and word accesses are steered with sign/zero extension selected by DMType. Out-of-range and invalid accesses are reported on an error flag instead of being silently performed.

## Interface
- ADDR_W, 32, byte-address width.
- DEPTH_WORDS, 1024, number of 32-bit words; power of two, at most 2^(ADDR_W-2).
- WAIT_CYCLES, 0, extra wait states per access; range 0..15.
- clk  in  1  clock; all state updates on the rising edge.
- rstn  in  1  asynchronous, active-low reset.
- req  in  1  access request; sampled only while ready=1.
- we  in  1  1=store, 0=load; qualified by req.
- addr  in  ADDR_W  byte address.
- dmtype  in  3  access type: DM_WORD, DM_HALFWORD, DM_HALFWORD_UNSIGNED, DM_BYTE, DM_BYTE_UNSIGNED.
- wdata  in  32  store data; low byte/halfword used for narrow stores.
- ready  out  1  block idle and able to accept a request.
- done  out  1  one-cycle completion pulse, for loads and stores.
- rdata  out  32  load result; valid when done=1 and the access was a load.
- err  out  1  valid with done; access was rejected and had no effect.

## Operation
- FSM states:
  - IDLE: ready=1.
  - WAIT: counts down WAIT_CYCLES.
  - RESP: done=1.
- Transitions:
  - In IDLE with req=1, the request is captured at the clock edge (we, addr, dmtype, wdata). Next state is WAIT if WAIT_CYCLES>0, otherwise RESP.
  - WAIT moves to RESP when the counter reaches 0.
  - RESP always moves to IDLE.
- The array is accessed at the edge entering RESP:
  - Stores write the selected byte lanes.
  - Loads register the extended result into rdata.
- Load extension:
  - Byte: lane addr[1:0].
  - Halfword: lane addr[1].
  - Signed types replicate the MSB; unsigned types zero-fill.
- err is set and the access is suppressed (no write; rdata=0) when any of these holds:
  - Word index addr[ADDR_W-1:2] >= DEPTH_WORDS.
  - dmtype is 5..7.
  - Misaligned access, if checking is compiled in (see Configuration).
- rdata holds its value outside done. done and err are 0 outside RESP.
- Array contents are not reset. Initial contents are undefined to the bench.

## Timing
- Reset values: state IDLE, ready=1, done=0, err=0, rdata=0, wait counter=0.
- Latency: a request accepted at edge T gives done=1 in cycle T+1+WAIT_CYCLES. ready returns high in the following cycle.
- Throughput: one access per WAIT_CYCLES+2 cycles.
- req while ready=0 is ignored. The requester must hold req until it observes ready=1.
- Back-to-back requests: a req held during the done cycle is not accepted. It is accepted one cycle later, in IDLE.
- A store followed by a load to the same address returns the stored data. No forwarding is needed, because accesses are serialised.
- Reset during WAIT: the pending access is abandoned and no write occurs.
- Reset asserted coincident with the RESP-entry edge: the write may be lost. The bench must not check this case.

## Configuration
- DMEM_MISALIGN_CHECK_EN defined:
  - Halfword access with addr[0]=1, or word access with addr[1:0]!=0, completes with err=1.
  - No write; rdata=0.
- Not defined:
  - Offending low address bits are ignored: addr[0] is cleared for halfwords, addr[1:0] for words.
  - The access proceeds normally with err=0.

## Structure
- dmtype encodings and FSM state constants go in the shared control-encoding definitions, next to existing ALU/NPC codes:
  - DM_WORD=3'b000
  - DM_HALFWORD=3'b001
  - DM_HALFWORD_UNSIGNED=3'b010
  - DM_BYTE=3'b011
  - DM_BYTE_UNSIGNED=3'b100
- One sub-module, dm_lane: combinational lane steering.
  - Produces the write byte-enable mask and positioned write data from dmtype, addr[1:0] and wdata.
  - Extracts and extends load data from the raw word.
- pl_dmem holds the FSM, wait counter, capture registers and the array.

## Test plan
- Reset: after rstn deasserts, ready=1, done=0, err=0, rdata=0.
- Store then load, WAIT_CYCLES=0:
  - sw 0x12345678 @0x10 gives done in cycle T+1 with err=0.
  - lw @0x10 then returns 0x12345678.
- Narrow access (memory holds 0x12345678 @0x10):
  - sb 0xAB @0x13, then lw @0x10 returns 0xAB345678.
  - lb @0x13 returns 0xFFFFFFAB.
  - lbu @0x13 returns 0x000000AB.
  - lh @0x12 returns 0xFFFFAB34.
- Wait states, WAIT_CYCLES=3:
  - Request accepted at edge T gives done exactly in cycle T+4.
  - ready=0 in cycles T+1..T+4; req pulses in that window are ignored.
- Errors:
  - lw @ (DEPTH_WORDS*4) gives err=1, rdata=0, and memory unchanged.
  - dmtype=3'b111 gives err=1.
  - With DMEM_MISALIGN_CHECK_EN, sw @0x11 gives err=1 and a following lw @0x10 shows no change. Without the macro, it writes word 0x10.
- Reset mid-access: with WAIT_CYCLES=3, assert rstn=0 in cycle T+2 of sw 0xDEADBEEF @0x20. Afterwards lw @0x20 returns the prior value and ready=1.
